lcd_sequencer: RTL and testbench
================================

LCD_SEQUENCER -- requirements
Module: lcd_sequencer

Interface
REQ-001 Parameter PWR_WAIT, default 1500000: power-up delay in clk cycles before the first command.
REQ-002 Parameter EN_CYCLES, default 4: number of cycles lcd_en is high per issued item.
REQ-003 Parameter CMD_WAIT, default 4000: idle cycles after every item except clear.
REQ-004 Parameter CLEAR_WAIT, default 160000: idle cycles after the clear command (0x01).
REQ-005 Parameter REFRESH_CYCLES, default 10000000: auto-refresh period; used only under LCD_AUTO_REFRESH_EN.
REQ-006 Port clk  in  1: single clock; all logic SHALL be on its rising edge.
REQ-007 Port rst  in  1: asynchronous, active-low reset.
REQ-008 Port buf_we  in  1: character buffer write strobe.
REQ-009 Port buf_addr  in  5: buffer index; 0-15 is line 1, 16-31 is line 2.
REQ-010 Port buf_data  in  8: ASCII character to store.
REQ-011 Port upd_req  in  1: request to refresh the display from the buffer.
REQ-012 Port upd_ack  out  1: one-cycle pulse when a refresh completes.
REQ-013 Port ready  out  1: high when init is done and the FSM is in IDLE.
REQ-014 Port busy  out  1: high in every state except IDLE.
REQ-015 Port lcd_write  out  1: display_controller write input; 1 = data, 0 = command.
REQ-016 Port lcd_ascii  out  8: display_controller ascii_data input.
REQ-017 Port lcd_en  out  1: LCD enable strobe.

Function
REQ-018 The block SHALL hold a 32x8 register buffer; buf_we writes buf_data at buf_addr on the clock edge.
REQ-019 FSM states: PWR, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2, DONE.
REQ-020 Item issue: drive lcd_write/lcd_ascii, hold lcd_en=1 for EN_CYCLES, then lcd_en=0 for the wait count; lcd_write/lcd_ascii SHALL stay stable for the whole item.
REQ-021 PWR SHALL count PWR_WAIT cycles, then go to INIT.
REQ-022 INIT SHALL issue commands 0x38, 0x0C, 0x01, 0x06 in order, then enter IDLE.
REQ-023 Refresh sequence: ADDR1 issues cmd 0x80; LINE1 issues data for buffer 0-15; ADDR2 issues cmd 0xC0; LINE2 issues data for buffer 16-31; DONE.
REQ-024 A refresh is 34 items; each character SHALL be read from the buffer in the first cycle of its item.
REQ-025 If buf_we targets the address being read in the same cycle, the old value SHALL be issued.
REQ-026 DONE SHALL pulse upd_ack for exactly one cycle and return to IDLE.
REQ-027 In IDLE, upd_req=1 (or a set pending flag) SHALL start a refresh on the next cycle.
REQ-028 upd_req=1 outside IDLE SHALL set a one-deep pending flag; further requests merge; the flag clears when its refresh starts.
REQ-029 Buffer writes SHALL be accepted in every state, including during PWR, INIT and refresh.
REQ-030 ready SHALL first go high on the first cycle in IDLE after INIT and stay low in PWR and INIT.

Reset
REQ-031 rst=0 SHALL immediately force PWR, clear all counters and the pending flag, and set every buffer entry to 0x20.
REQ-032 Reset values: lcd_en=0, lcd_write=0, lcd_ascii=0x00, upd_ack=0, ready=0, busy=1.
REQ-033 Reset asserted mid-item SHALL abort the item; after release the full PWR and INIT sequence SHALL repeat.

Configuration
REQ-034 Macro LCD_AUTO_REFRESH_EN: when defined, a counter SHALL count REFRESH_CYCLES while ready=1 and trigger a refresh in IDLE on expiry.
REQ-035 The auto-refresh counter SHALL reload on every refresh start.
REQ-036 Without LCD_AUTO_REFRESH_EN, the counter SHALL not exist and refreshes SHALL occur only via upd_req.

Verification (PWR_WAIT=10, EN_CYCLES=2, CMD_WAIT=4, CLEAR_WAIT=8, REFRESH_CYCLES=200)
REQ-037 Release reset -> lcd_en=0 for 10 cycles, then items 0x38/0x0C/0x01/0x06 with lcd_write=0; gap after 0x01 is 8 cycles; ready=1 after the last item.
REQ-038 Write "A" at addr 0 and "Z" at addr 31, then pulse upd_req -> 0x80 cmd, 0x41 data, fifteen 0x20 data, 0xC0 cmd, fifteen 0x20 data, 0x5A data, one-cycle upd_ack.
REQ-039 upd_req pulsed twice during a refresh -> exactly one extra refresh follows; two upd_ack pulses in total.
REQ-040 rst=0 during LINE1 item 5 -> outputs at reset values the same cycle; after release the init sequence repeats and the buffer reads 0x20.
REQ-041 buf_we to addr 3 with 0x42 in the same cycle addr 3 is read -> old value issued; the next refresh issues 0x42.
REQ-042 LCD_AUTO_REFRESH_EN defined with no upd_req -> refresh starts 200 cycles after ready; with the macro undefined, no refresh occurs.

Source files
------------

// File: rtl/lcd_sequencer.sv
// Character-LCD sequencer: power-up wait, four init commands, then two-line refresh from a 32x8 buffer.
// Define LCD_AUTO_REFRESH_EN to add a periodic refresh timer running while the block is ready.
module lcd_sequencer #(
    parameter int PWR_WAIT       = 1500000,
    parameter int EN_CYCLES      = 4,
    parameter int CMD_WAIT       = 4000,
    parameter int CLEAR_WAIT     = 160000,
    parameter int REFRESH_CYCLES = 10000000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       buf_we,
    input  logic [4:0] buf_addr,
    input  logic [7:0] buf_data,
    input  logic       upd_req,
    output logic       upd_ack,
    output logic       ready,
    output logic       busy,
    output logic       lcd_write,
    output logic [7:0] lcd_ascii,
    output logic       lcd_en
);
    localparam int MAX_A = (PWR_WAIT > CLEAR_WAIT) ? PWR_WAIT : CLEAR_WAIT;
    localparam int MAX_B = (CMD_WAIT > EN_CYCLES) ? CMD_WAIT : EN_CYCLES;
    localparam int MAX_C = (MAX_A > MAX_B) ? MAX_A : MAX_B;
    localparam int MAX_W = (MAX_C > REFRESH_CYCLES) ? MAX_C : REFRESH_CYCLES;
    localparam int CW    = $clog2(MAX_W + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(PWR_WAIT - 1);
    localparam logic [CW-1:0] EN_LAST  = CW'(EN_CYCLES - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(CMD_WAIT - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(CLEAR_WAIT - 1);

    typedef enum logic [2:0] {PWR, INIT, IDLE, ADDR1, LINE1, ADDR2, LINE2, DONE} state_t;

    state_t          state_q;
    logic [CW-1:0]   cnt_q;
    logic            en_ph_q;
    logic [3:0]      itm_q;
    logic            pend_q;
    logic [31:0][7:0] buf_q;

    state_t          nxt_state_d;
    logic [3:0]      nxt_itm_d;
    logic            nxt_wr_d;
    logic [7:0]      nxt_ch_d;
    logic            issue_d;
    logic            adv_d;
    logic            start_d;
    logic            fire_d;
    logic [4:0]      rd_addr_d;
    logic [7:0]      rd_data_d;
    logic [CW-1:0]   wait_last_d;

    function automatic logic [7:0] init_cmd(input logic [1:0] i);
        case (i)
            2'd0:    return 8'h38;
            2'd1:    return 8'h0C;
            2'd2:    return 8'h01;
            default: return 8'h06;
        endcase
    endfunction

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) buf_q <= {32{8'h20}};
        else if (buf_we) buf_q[buf_addr] <= buf_data;
    end

    // Address of the character for the item loaded at the end of the current one.
    assign rd_addr_d   = {(state_q == ADDR2) || (state_q == LINE2),
                          ((state_q == LINE1) || (state_q == LINE2)) ? itm_q + 4'd1 : 4'd0};
    assign rd_data_d   = buf_q[rd_addr_d];
    assign wait_last_d = (state_q == INIT && itm_q == 4'd2) ? CLR_LAST : CMD_LAST;

`ifdef LCD_AUTO_REFRESH_EN
    localparam logic [CW-1:0] AR_LAST = CW'(REFRESH_CYCLES - 1);
    logic [CW-1:0] ar_cnt_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) ar_cnt_q <= '0;
        else if (state_q == IDLE && start_d) ar_cnt_q <= '0;
        else if (ready && ar_cnt_q != AR_LAST) ar_cnt_q <= ar_cnt_q + CW'(1);
    end

    assign fire_d = ready && (ar_cnt_q == AR_LAST);
`else
    assign fire_d = 1'b0;
`endif

    assign start_d = upd_req || pend_q || fire_d;

    always_comb begin
        nxt_state_d = IDLE;
        nxt_itm_d   = 4'd0;
        nxt_wr_d    = 1'b0;
        nxt_ch_d    = 8'h00;
        issue_d     = 1'b1;
        case (state_q)
            PWR: begin nxt_state_d = INIT; nxt_ch_d = 8'h38; end
            INIT:
                if (itm_q == 4'd3) issue_d = 1'b0;
                else begin
                    nxt_state_d = INIT;
                    nxt_itm_d   = itm_q + 4'd1;
                    nxt_ch_d    = init_cmd(itm_q[1:0] + 2'd1);
                end
            IDLE:  begin nxt_state_d = ADDR1; nxt_ch_d = 8'h80; end
            ADDR1: begin nxt_state_d = LINE1; nxt_wr_d = 1'b1; nxt_ch_d = rd_data_d; end
            LINE1:
                if (itm_q == 4'hF) begin nxt_state_d = ADDR2; nxt_ch_d = 8'hC0; end
                else begin
                    nxt_state_d = LINE1;
                    nxt_itm_d   = itm_q + 4'd1;
                    nxt_wr_d    = 1'b1;
                    nxt_ch_d    = rd_data_d;
                end
            ADDR2: begin nxt_state_d = LINE2; nxt_wr_d = 1'b1; nxt_ch_d = rd_data_d; end
            LINE2:
                if (itm_q == 4'hF) begin nxt_state_d = DONE; issue_d = 1'b0; end
                else begin
                    nxt_state_d = LINE2;
                    nxt_itm_d   = itm_q + 4'd1;
                    nxt_wr_d    = 1'b1;
                    nxt_ch_d    = rd_data_d;
                end
            default: issue_d = 1'b0;
        endcase
    end

    always_comb begin
        adv_d = 1'b0;
        case (state_q)
            PWR:     adv_d = (cnt_q == PWR_LAST);
            IDLE:    adv_d = start_d;
            DONE:    adv_d = 1'b1;
            default: adv_d = !en_ph_q && (cnt_q == wait_last_d);
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= PWR;
            cnt_q     <= '0;
            en_ph_q   <= 1'b0;
            itm_q     <= 4'd0;
            pend_q    <= 1'b0;
            lcd_en    <= 1'b0;
            lcd_write <= 1'b0;
            lcd_ascii <= 8'h00;
            upd_ack   <= 1'b0;
            ready     <= 1'b0;
            busy      <= 1'b1;
        end else begin
            if (upd_req && state_q != IDLE) pend_q <= 1'b1;
            if (adv_d) begin
                state_q <= nxt_state_d;
                itm_q   <= nxt_itm_d;
                cnt_q   <= '0;
                en_ph_q <= issue_d;
                lcd_en  <= issue_d;
                if (issue_d) begin
                    lcd_write <= nxt_wr_d;
                    lcd_ascii <= nxt_ch_d;
                end
                upd_ack <= (nxt_state_d == DONE);
                ready   <= (nxt_state_d == IDLE);
                busy    <= (nxt_state_d != IDLE);
                if (state_q == IDLE) pend_q <= 1'b0;
            end else begin
                upd_ack <= 1'b0;
                if (en_ph_q) begin
                    if (cnt_q == EN_LAST) begin
                        en_ph_q <= 1'b0;
                        lcd_en  <= 1'b0;
                        cnt_q   <= '0;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end else if (state_q != IDLE) begin
                    cnt_q <= cnt_q + CW'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_lcd_sequencer.sv
// Directed bench for lcd_sequencer: init timing, refresh contents, request merging, read/write collision, reset abort.
module tb_lcd_sequencer;
    localparam int PWR_T = 10;
    localparam int EN_T  = 2;
    localparam int CMD_T = 4;
    localparam int CLR_T = 8;
    localparam int REF_T = 200;

    logic       clk, rst, buf_we, upd_req;
    logic [4:0] buf_addr;
    logic [7:0] buf_data;
    logic       upd_ack, ready, busy, lcd_write, lcd_en;
    logic [7:0] lcd_ascii;

    int checks   = 0;
    int failures = 0;
    int acks     = 0;
    logic [7:0] model [32];

    lcd_sequencer #(
        .PWR_WAIT(PWR_T), .EN_CYCLES(EN_T), .CMD_WAIT(CMD_T),
        .CLEAR_WAIT(CLR_T), .REFRESH_CYCLES(REF_T)
    ) dut (
        .clk(clk), .rst(rst), .buf_we(buf_we), .buf_addr(buf_addr), .buf_data(buf_data),
        .upd_req(upd_req), .upd_ack(upd_ack), .ready(ready), .busy(busy),
        .lcd_write(lcd_write), .lcd_ascii(lcd_ascii), .lcd_en(lcd_en)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) if (upd_ack === 1'b1) acks++;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic rst_vals(input string tag);
        check(tag, 32'({lcd_en, lcd_write, lcd_ascii, upd_ack, ready, busy}), 32'h001);
    endtask

    // One item: lcd_en high EN_T cycles, then low for gap cycles, data held throughout.
    task automatic item(input string tag, input logic wr, input logic [7:0] ch,
                        input int gap, input int maxw);
        int n;
        bit ok;
        logic [7:0] c0;
        logic w0;
        n = 0;
        while (lcd_en !== 1'b1 && n < maxw) begin tick(); n++; end
        check($sformatf("%s_start", tag), 32'(lcd_en), 32'd1);
        c0 = lcd_ascii;
        w0 = lcd_write;
        ok = 1'b1;
        for (int i = 0; i < EN_T + gap; i++) begin
            if (lcd_en !== (i < EN_T) || lcd_ascii !== c0 || lcd_write !== w0 ||
                upd_ack !== 1'b0 || busy !== 1'b1 || ready !== 1'b0) ok = 1'b0;
            tick();
        end
        check($sformatf("%s_data", tag), 32'({w0, c0}), 32'({wr, ch}));
        check($sformatf("%s_shape", tag), 32'(ok), 32'd1);
    endtask

    task automatic do_init(input string tag, input bit pwr_write);
        bit ok;
        ok = 1'b1;
        for (int i = 1; i <= PWR_T - 1; i++) begin
            if (pwr_write && i == 3) begin
                buf_we = 1'b1; buf_addr = 5'd9; buf_data = 8'h39; model[9] = 8'h39;
            end
            tick();
            buf_we = 1'b0;
            if (lcd_en !== 1'b0 || ready !== 1'b0 || busy !== 1'b1) ok = 1'b0;
        end
        check($sformatf("%s_pwr", tag), 32'(ok), 32'd1);
        item($sformatf("%s_38", tag), 1'b0, 8'h38, CMD_T, 1);
        item($sformatf("%s_0C", tag), 1'b0, 8'h0C, CMD_T, 0);
        item($sformatf("%s_01", tag), 1'b0, 8'h01, CLR_T, 0);
        item($sformatf("%s_06", tag), 1'b0, 8'h06, CMD_T, 0);
        check($sformatf("%s_ready", tag), 32'({lcd_en, ready, busy}), 32'b010);
    endtask

    task automatic do_refresh(input string tag, input int maxw);
        item($sformatf("%s_a80", tag), 1'b0, 8'h80, CMD_T, maxw);
        for (int k = 0; k < 16; k++) item($sformatf("%s_c%0d", tag, k), 1'b1, model[k], CMD_T, 0);
        item($sformatf("%s_aC0", tag), 1'b0, 8'hC0, CMD_T, 0);
        for (int k = 16; k < 32; k++) item($sformatf("%s_c%0d", tag, k), 1'b1, model[k], CMD_T, 0);
        check($sformatf("%s_ack", tag), 32'({upd_ack, ready, busy}), 32'b101);
        tick();
        check($sformatf("%s_idle", tag), 32'({upd_ack, ready, busy}), 32'b010);
    endtask

    task automatic pulse_refresh(input string tag);
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        do_refresh(tag, 0);
    endtask

    task automatic wr_buf(input logic [4:0] a, input logic [7:0] d);
        buf_we = 1'b1; buf_addr = a; buf_data = d;
        tick();
        buf_we = 1'b0;
        model[a] = d;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int a0, n;
        bit ok;
        rst = 1'b1; buf_we = 1'b0; buf_addr = '0; buf_data = '0; upd_req = 1'b0;
        for (int k = 0; k < 32; k++) model[k] = 8'h20;
        #2 rst = 1'b0;
        #1 rst_vals("rst_async");
        tick();
        rst_vals("rst_held");
        rst = 1'b1;
        do_init("i1", 1'b0);

        // "A" at 0, "Z" at 31
        wr_buf(5'd0, 8'h41);
        wr_buf(5'd31, 8'h5A);
        pulse_refresh("r1");

        // Two requests during a refresh merge into one follow-up refresh
        a0 = acks;
        upd_req = 1'b1;
        fork
            begin tick(); upd_req = 1'b0; do_refresh("r2", 0); end
            begin
                repeat (30) @(posedge clk);
                #1 upd_req = 1'b1;
                @(posedge clk);
                #1 upd_req = 1'b0;
                repeat (60) @(posedge clk);
                #1 upd_req = 1'b1;
                @(posedge clk);
                #1 upd_req = 1'b0;
            end
        join
        do_refresh("r3", 1);
        ok = 1'b1;
        for (int i = 0; i < 30; i++) begin
            tick();
            if (lcd_en !== 1'b0 || busy !== 1'b0 || ready !== 1'b1) ok = 1'b0;
        end
        check("merge_quiet", 32'(ok), 32'd1);
        check("merge_acks", 32'(acks - a0), 32'd2);

        // Write addr 3 on the same edge that loads its item: old value goes out
        upd_req = 1'b1;
        fork
            begin tick(); upd_req = 1'b0; do_refresh("r4", 0); end
            begin
                repeat (24) @(posedge clk);
                #1 buf_we = 1'b1; buf_addr = 5'd3; buf_data = 8'h42;
                @(posedge clk);
                #1 buf_we = 1'b0;
            end
        join
        model[3] = 8'h42;
        pulse_refresh("r5");

`ifdef LCD_AUTO_REFRESH_EN
        n = 0;
        while (lcd_en !== 1'b1 && n < REF_T + 60) begin tick(); n++; end
        check("auto_delay", 32'(n), 32'(REF_T));
        do_refresh("ra", 0);
`else
        ok = 1'b1;
        for (int i = 0; i < REF_T + 50; i++) begin
            tick();
            if (lcd_en !== 1'b0 || busy !== 1'b0) ok = 1'b0;
        end
        check("no_auto", 32'(ok), 32'd1);
`endif

        // Reset in the middle of LINE1 item 5
        upd_req = 1'b1;
        tick();
        upd_req = 1'b0;
        repeat (36) tick();
        check("mid_item", 32'({lcd_en, lcd_write}), 32'b11);
        #2 rst = 1'b0;
        #1 rst_vals("rst_mid");
        tick();
        rst_vals("rst_mid_held");
        rst = 1'b1;
        for (int k = 0; k < 32; k++) model[k] = 8'h20;
        do_init("i2", 1'b1);
        pulse_refresh("r6");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
